// File: rtl/led_pwm_pkg.sv
// Shared mode encodings and default parameters for the LED PWM controller.
package led_pwm_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   localparam int unsigned DEF_CHANNELS      = 3;
   localparam int unsigned DEF_PWM_BITS      = 8;
   localparam int unsigned DEF_PRESCALE_LOG2 = 16;
   localparam int unsigned DEF_DEBOUNCE_LOG2 = 16;

endpackage

// File: rtl/led_btn_debounce.sv
// One button: 2-flop synchroniser, restartable debounce counter and press-edge detect.
module led_btn_debounce
   import led_pwm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_LOG2 = DEF_DEBOUNCE_LOG2
) (
   input  logic clki,
   input  logic rstn,
   input  logic btn_n_i,
   output logic press_o
);

   localparam logic [DEBOUNCE_LOG2-1:0] CNT_ONE = 1;

   logic [1:0]               sync_q;
   logic [1:0]               vld_q;
   logic                     stable_q, stable_d;
   logic [DEBOUNCE_LOG2-1:0] cnt_q, cnt_d;
   logic                     arm_q, arm_d;
   logic                     differ, expired;

   assign differ  = sync_q[1] ^ stable_q;
   assign expired = differ & (&cnt_q);

   // Events stay disarmed until a real released sample has left the
   // synchroniser, so a button held through reset never produces a press.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      arm_d    = arm_q | (vld_q[1] & sync_q[1]);
      if (expired)     stable_d = sync_q[1];
      else if (differ) cnt_d    = cnt_q + CNT_ONE;
   end

   assign press_o = expired & arm_q & ~sync_q[1];

   always_ff @(posedge clki or negedge rstn) begin
      if (!rstn) begin
         sync_q   <= 2'b11;
         vld_q    <= 2'b00;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         arm_q    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_n_i};
         vld_q    <= {vld_q[0], 1'b1};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         arm_q    <= arm_d;
      end
   end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM with off/on/blink/breathe modes and debounced toggle buttons.
module led_pwm_ctrl
   import led_pwm_pkg::*;
#(
   parameter int unsigned CHANNELS      = DEF_CHANNELS,
   parameter int unsigned PWM_BITS      = DEF_PWM_BITS,
   parameter int unsigned PRESCALE_LOG2 = DEF_PRESCALE_LOG2,
   parameter int unsigned DEBOUNCE_LOG2 = DEF_DEBOUNCE_LOG2
) (
   input  logic                         clki,
   input  logic                         rstn,
   input  logic [CHANNELS-1:0]          btn_n,
   input  logic [2*CHANNELS-1:0]        mode,
   input  logic [PWM_BITS*CHANNELS-1:0] duty,
   output logic [CHANNELS-1:0]          pwm_out,
   output logic [CHANNELS-1:0]          btn_evt,
   output logic [CHANNELS-1:0]          chan_en
);

   localparam logic [PWM_BITS-1:0]      PWM_ONE   = 1;
   localparam logic [PRESCALE_LOG2-1:0] PRESC_ONE = 1;

   logic [PWM_BITS-1:0]      pwm_cnt_q;
   logic [PRESCALE_LOG2-1:0] presc_q;
   logic [7:0]               tick_cnt_q;
   logic                     tick, blink_phase, period_end;

   logic [CHANNELS-1:0][PWM_BITS-1:0] breathe_lvl;

   assign tick        = &presc_q;
   assign blink_phase = tick_cnt_q[7];
   assign period_end  = &pwm_cnt_q;

   always_ff @(posedge clki or negedge rstn) begin
      if (!rstn) begin
         pwm_cnt_q  <= '0;
         presc_q    <= '0;
         tick_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + PWM_ONE;
         presc_q   <= presc_q + PRESC_ONE;
         if (tick) tick_cnt_q <= tick_cnt_q + 8'd1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      mode_e               m;
      logic [PWM_BITS-1:0] d;
      logic [PWM_BITS-1:0] lvl_q, lvl_d;
      logic                fall_q, fall_d;
      logic [PWM_BITS-1:0] level_q, target;
      logic                pwm_q, evt_q, en_q;
      logic                press;

      assign m = mode_e'(mode[2*i +: 2]);
      assign d = duty[PWM_BITS*i +: PWM_BITS];
      assign breathe_lvl[i] = lvl_q;

      // The ramp turns at the ends without repeating the peak or the floor;
      // a duty lowered mid-ramp clamps the level instead of overshooting it.
      always_comb begin
         lvl_d  = lvl_q;
         fall_d = fall_q;
         if (m != MODE_BREATHE) begin
            lvl_d  = '0;
            fall_d = 1'b0;
         end else if (tick) begin
            if (!fall_q) begin
               if (lvl_q >= d) begin
                  fall_d = 1'b1;
                  if (lvl_q > d)        lvl_d = d;
                  else if (lvl_q != '0) lvl_d = lvl_q - PWM_ONE;
               end else begin
                  lvl_d = lvl_q + PWM_ONE;
               end
            end else begin
               if (lvl_q == '0) begin
                  fall_d = 1'b0;
                  if (d != '0) lvl_d = PWM_ONE;
               end else if (lvl_q > d) begin
                  lvl_d = d;
               end else begin
                  lvl_d = lvl_q - PWM_ONE;
               end
            end
         end
      end

      always_comb begin
         target = '0;
         case (m)
            MODE_OFF:     target = '0;
            MODE_ON:      target = d;
            MODE_BLINK:   target = blink_phase ? d : '0;
            MODE_BREATHE: target = (breathe_lvl[i] > d) ? d : breathe_lvl[i];
            default:      target = '0;
         endcase
      end

      led_btn_debounce #(
         .DEBOUNCE_LOG2 (DEBOUNCE_LOG2)
      ) u_btn (
         .clki    (clki),
         .rstn    (rstn),
         .btn_n_i (btn_n[i]),
         .press_o (press)
      );

      always_ff @(posedge clki or negedge rstn) begin
         if (!rstn) begin
            lvl_q   <= '0;
            fall_q  <= 1'b0;
            level_q <= '0;
            pwm_q   <= 1'b0;
            evt_q   <= 1'b0;
            en_q    <= 1'b1;
         end else begin
            lvl_q  <= lvl_d;
            fall_q <= fall_d;
            if (period_end) level_q <= target;
            pwm_q  <= en_q & (pwm_cnt_q < level_q);
            evt_q  <= press;
            en_q   <= en_q ^ press;
         end
      end

      assign pwm_out[i] = pwm_q;
      assign btn_evt[i] = evt_q;
      assign chan_en[i] = en_q;
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: PWM duty, breathe ramp, blink period, buttons and reset.
module tb_led_pwm_ctrl;
   import led_pwm_pkg::*;

   localparam int CH = 3;
   localparam int PB = 4;
   localparam int PL = 2;
   localparam int DL = 3;

   logic              clki = 1'b0;
   logic              rstn = 1'b0;
   logic [CH-1:0]     btn_n = '1;
   logic [2*CH-1:0]   mode = '0;
   logic [PB*CH-1:0]  duty = '0;
   logic [CH-1:0]     pwm_out, btn_evt, chan_en;

   led_pwm_ctrl #(
      .CHANNELS      (CH),
      .PWM_BITS      (PB),
      .PRESCALE_LOG2 (PL),
      .DEBOUNCE_LOG2 (DL)
   ) dut (
      .clki    (clki),
      .rstn    (rstn),
      .btn_n   (btn_n),
      .mode    (mode),
      .duty    (duty),
      .pwm_out (pwm_out),
      .btn_evt (btn_evt),
      .chan_en (chan_en)
   );

   always #5 clki = ~clki;

   int cyc = 0;
   always @(posedge clki) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      int            cyc;
      logic [CH-1:0] mask;
   } evt_t;

   evt_t          evq[$];
   evt_t          mon_e;
   int            exq[$];
   string         tgq[$];
   logic [CH-1:0] exp_en;

   // Every observed press pulse must match the oldest expected one.
   always @(negedge clki) begin
      if (rstn && btn_evt !== '0) begin
         if (evq.size() == 0) begin
            chk("evt_unexpected", btn_evt, 0);
         end else begin
            mon_e = evq.pop_front();
            chk("evt_cycle", cyc, mon_e.cyc);
            chk("evt_mask", btn_evt, mon_e.mask);
         end
      end
   end

   task automatic set_ch(input int ch, input mode_e m, input int d);
      logic [31:0] dv;
      dv = d;
      mode[2*ch +: 2]  = m;
      duty[PB*ch +: PB] = dv[PB-1:0];
   endtask

   task automatic exp_pwm(input string tag, input int ch, input int exp);
      int cnt;
      tgq.push_back(tag);
      exq.push_back(exp);
      repeat (40) @(negedge clki);
      cnt = 0;
      repeat (16) begin
         @(negedge clki);
         cnt += int'(pwm_out[ch]);
      end
      chk(tgq.pop_front(), cnt, exq.pop_front());
   endtask

   task automatic press(input logic [CH-1:0] mask);
      btn_n = btn_n & ~mask;
      evq.push_back(evt_t'{cyc + 10, mask});
      exp_en = exp_en ^ mask;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int prev, cur, lows, highs;
      int starts[$];

      repeat (3) @(negedge clki);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_evt", btn_evt, 0);
      chk("rst_en", chan_en, 3'b111);
      rstn   = 1'b1;
      exp_en = '1;

      set_ch(0, MODE_ON, 5);  exp_pwm("on_duty5", 0, 5);
      set_ch(0, MODE_ON, 0);  exp_pwm("on_duty0", 0, 0);
      set_ch(0, MODE_ON, 15); exp_pwm("on_duty15", 0, 15);
      exp_pwm("off_ch1", 1, 0);

      set_ch(0, MODE_BREATHE, 0);
      exp_pwm("breathe_duty0", 0, 0);
      chk("breathe_duty0_lvl", dut.breathe_lvl[0], 0);
      set_ch(0, MODE_OFF, 0);

      foreach (starts[k]) starts.delete();
      begin
         int seq[7] = '{1, 2, 3, 2, 1, 0, 1};
         foreach (seq[k]) begin
            exq.push_back(seq[k]);
            tgq.push_back($sformatf("breathe_step%0d", k));
         end
      end
      set_ch(2, MODE_BREATHE, 3);
      prev = 0;
      for (int k = 0; k < 300 && exq.size() > 0; k++) begin
         @(negedge clki);
         cur = int'(dut.breathe_lvl[2]);
         if (cur != prev) begin
            chk(tgq.pop_front(), cur, exq.pop_front());
            prev = cur;
         end
      end
      if (exq.size() != 0) begin
         chk("breathe_timeout", exq.size(), 0);
         exq.delete();
         tgq.delete();
      end
      set_ch(2, MODE_ON, 3);
      @(negedge clki);
      chk("breathe_exit_lvl", dut.breathe_lvl[2], 0);
      exp_pwm("breathe_to_on", 2, 3);

      exq.push_back(1024); tgq.push_back("blink_period");
      exq.push_back(480);  tgq.push_back("blink_on_highs");
      set_ch(0, MODE_BLINK, 15);
      lows = 0;
      highs = 0;
      for (int k = 0; k < 4000 && starts.size() < 3; k++) begin
         @(negedge clki);
         if (pwm_out[0]) begin
            if (lows >= 16) starts.push_back(k);
            lows = 0;
         end else begin
            lows++;
         end
         if (starts.size() == 2 && k < starts[1] + 512) highs += int'(pwm_out[0]);
      end
      if (starts.size() < 3) begin
         chk("blink_timeout", starts.size(), 3);
         exq.delete();
         tgq.delete();
      end else begin
         chk(tgq.pop_front(), starts[2] - starts[1], exq.pop_front());
         chk(tgq.pop_front(), highs, exq.pop_front());
      end
      set_ch(0, MODE_ON, 15);

      repeat (2) begin
         btn_n[1] = 1'b0; repeat (3) @(negedge clki);
         btn_n[1] = 1'b1; repeat (3) @(negedge clki);
      end
      press(3'b010);
      repeat (20) @(negedge clki);
      chk("en_after_press1", chan_en, exp_en);
      btn_n[1] = 1'b1;
      repeat (30) @(negedge clki);
      chk("evt_pending1", evq.size(), 0);
      chk("en_after_release1", chan_en, exp_en);

      press(3'b101);
      repeat (20) @(negedge clki);
      chk("en_after_dual", chan_en, exp_en);
      exp_pwm("disabled_ch0", 0, 0);
      exp_pwm("disabled_ch2", 2, 0);
      btn_n = '1;
      repeat (30) @(negedge clki);
      chk("evt_pending2", evq.size(), 0);

      set_ch(2, MODE_BREATHE, 3);
      repeat (30) @(negedge clki);
      btn_n[2] = 1'b0;
      repeat (4) @(negedge clki);
      rstn = 1'b0;
      #1;
      chk("rst2_pwm", pwm_out, 0);
      chk("rst2_evt", btn_evt, 0);
      chk("rst2_en", chan_en, 3'b111);
      chk("rst2_breathe", dut.breathe_lvl[2], 0);
      exp_en = '1;
      repeat (3) @(negedge clki);
      rstn = 1'b1;
      repeat (40) @(negedge clki);
      chk("en_after_rst2_held", chan_en, 3'b111);
      btn_n[2] = 1'b1;
      repeat (30) @(negedge clki);
      press(3'b100);
      repeat (20) @(negedge clki);
      btn_n[2] = 1'b1;
      repeat (30) @(negedge clki);
      chk("evt_pending3", evq.size(), 0);
      chk("en_after_rearm", chan_en, exp_en);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent LED channels.
REQ-002 Parameter PWM_BITS, default 8: PWM resolution and duty/level width.
REQ-003 Parameter PRESCALE_LOG2, default 16: the ramp/blink tick period is 2**PRESCALE_LOG2 clocks.
REQ-004 Parameter DEBOUNCE_LOG2, default 16: a button input SHALL be stable for 2**DEBOUNCE_LOG2 clocks before it is accepted.
REQ-005 clki  in  1  single system clock; all logic on posedge clki.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 btn_n  in  CHANNELS  raw active-low touch/button inputs, asynchronous to clki.
REQ-008 mode  in  2*CHANNELS  per-channel mode (2 bits each): 00 off, 01 on, 10 blink, 11 breathe.
REQ-009 duty  in  PWM_BITS*CHANNELS  per-channel peak level.
REQ-010 pwm_out  out  CHANNELS  registered PWM drive, intended for SB_RGBA_DRV RGBnPWM inputs.
REQ-011 btn_evt  out  CHANNELS  one-cycle pulse per accepted press.
REQ-012 chan_en  out  CHANNELS  current per-channel enable state.

Function
REQ-013 pwm_cnt (PWM_BITS) SHALL increment every clock and wrap from all-ones to 0.
REQ-014 Prescaler (PRESCALE_LOG2 bits) SHALL free-run; tick SHALL pulse for one cycle when the prescaler is all-ones.
REQ-015 tick_cnt (8 bits) SHALL increment on each tick and wrap; blink_phase SHALL equal tick_cnt[7].
REQ-016 Target level per mode: off = 0; on = duty; blink = duty when blink_phase is 1, else 0; breathe = breathe_lvl.
REQ-017 Breathe: on each tick, breathe_lvl SHALL step +1 while rising and -1 while falling.
- Direction SHALL flip to falling when breathe_lvl >= duty.
- Direction SHALL flip to rising when breathe_lvl == 0.
- breathe_lvl SHALL never exceed duty and SHALL never wrap.
REQ-018 While the mode is not breathe, breathe_lvl SHALL be held at 0 with direction rising; entering breathe SHALL start from 0.
REQ-019 With duty = 0 in breathe mode, breathe_lvl SHALL stay 0 and the output SHALL stay low.
REQ-020 level_reg SHALL load the target level only in the cycle where pwm_cnt is all-ones, so a PWM period never glitches; mode and duty changes take effect at the next period boundary.
REQ-021 pwm_out[i] SHALL be registered as chan_en[i] AND (pwm_cnt < level_reg[i]); latency is one clock from pwm_cnt.
- duty = 2**PWM_BITS-1 SHALL give high for 2**PWM_BITS-1 of 2**PWM_BITS clocks.
- Level 0 SHALL give constant low.
REQ-022 Each btn_n bit SHALL pass a 2-flop synchroniser, then the debouncer.
- The debounced state SHALL update only after the synchronised value differs from it for 2**DEBOUNCE_LOG2 consecutive clocks.
- Any bounce SHALL restart the count.
REQ-023 A debounced 1->0 transition SHALL pulse btn_evt[i] for exactly one clock and toggle chan_en[i] in that same clock; release SHALL produce no event.
REQ-024 Simultaneous presses on several channels SHALL be handled independently in the same cycle.
REQ-025 A press held indefinitely SHALL produce exactly one event.

Reset
REQ-026 On rstn low, the following SHALL clear asynchronously: pwm_cnt, prescaler, tick_cnt, breathe_lvl = 0, direction rising, level_reg = 0.
REQ-027 On rstn low: pwm_out = 0, btn_evt = 0, chan_en = all-ones, synchronisers and debounced state = 1 (released), debounce counters = 0.
REQ-028 Reset assertion mid-period or mid-debounce SHALL abandon the operation; no btn_evt SHALL be emitted on deassertion even if a button is held.
REQ-029 Reset deassertion SHALL be used synchronised to clki by the instantiating top level.

Structure
REQ-030 Shared package led_pwm_pkg SHALL hold the mode encodings (MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE) and the default parameter constants.
REQ-031 Synchroniser, debounce counter and press-edge detect SHALL be one sub-module, led_btn_debounce (parameter DEBOUNCE_LOG2), instantiated CHANNELS times.
REQ-032 PWM counter, prescaler and tick_cnt SHALL be shared across channels; breathe_lvl, direction and level_reg SHALL be per channel.

Verification (bench parameters: PWM_BITS=4, PRESCALE_LOG2=2, DEBOUNCE_LOG2=3, CHANNELS=3)
REQ-033 mode=on, duty=5, ch0 -> pwm_out[0] high for exactly 5 of every 16 clocks after the first period boundary; duty=0 -> constant low; duty=15 -> high 15/16.
REQ-034 mode=breathe, duty=3 -> level sequence per tick: 0,1,2,3,2,1,0,1...; mode switched to on mid-ramp -> level = duty at the next period boundary, breathe_lvl = 0.
REQ-035 btn_n[1] low with 3-clock bounce pulses, then held low 20 clocks -> exactly one btn_evt[1] pulse, 8 clocks after last bounce + 2 sync clocks; chan_en[1] goes 1->0; release gives no event.
REQ-036 btn_n[0] and btn_n[2] pressed in the same cycle -> both btn_evt pulses in the same cycle, both enables toggle; pwm_out is 0 on disabled channels.
REQ-037 rstn asserted while ch2 is breathing and btn_n[2] is held -> all outputs go to reset values immediately; after release, no btn_evt while still held; chan_en = 3'b111.
REQ-038 mode=blink, duty=15 -> pwm_out toggles between 15/16 duty and off every 128 ticks (512 clocks).
